// File: rtl/param_instr_data_mem.sv
// Instruction memory with write-first fetch and a self-clearing data memory
// with a two-stage read pipeline and same-address store forwarding.
module param_instr_data_mem #(
  parameter int unsigned IADDR_W = 10,
  parameter int unsigned IDATA_W = 16,
  parameter int unsigned DADDR_W = 8,
  parameter int unsigned DDATA_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IADDR_W-1:0] prog_ctr,
  input  logic               fetch_en,
  output logic [IDATA_W-1:0] instr_mem_out,
  output logic               instr_valid,
  input  logic               imem_wr_en,
  input  logic [IADDR_W-1:0] imem_wr_addr,
  input  logic [IDATA_W-1:0] imem_wr_data,
  input  logic               data_rd_en,
  input  logic [DADDR_W-1:0] data_rd_addr,
  output logic [DDATA_W-1:0] datamem_rd_data,
  output logic               datamem_rd_valid,
  input  logic               store_to_mem,
  input  logic [DADDR_W-1:0] data_wr_addr,
  input  logic [DDATA_W-1:0] datamem_wr_data,
  output logic               mem_busy
);

  localparam int unsigned IDEPTH = 2 ** IADDR_W;
  localparam int unsigned DDEPTH = 2 ** DADDR_W;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  logic [IDATA_W-1:0] imem [IDEPTH];
  logic [DDATA_W-1:0] dmem [DDEPTH];

  state_t             state;
  state_t             state_next;
  logic [DADDR_W-1:0] clr_ctr;
  logic               clr_last_c;

  logic               mem_we_c;
  logic [DADDR_W-1:0] mem_waddr_c;
  logic [DDATA_W-1:0] mem_wdata_c;
  logic               rd_req_c;
  logic               rd_fwd_c;

  logic               rd_v1;
  logic [DDATA_W-1:0] rd_d1;

  // Instruction storage is never reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (imem_wr_en) imem[imem_wr_addr] <= imem_wr_data;
  end

  // Fetch register with write-first bypass of a same-cycle load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_valid   <= 1'b0;
      instr_mem_out <= '0;
    end else begin
      instr_valid <= fetch_en;
      if (fetch_en) begin
        if (imem_wr_en && (imem_wr_addr == prog_ctr)) instr_mem_out <= imem_wr_data;
        else                                           instr_mem_out <= imem[prog_ctr];
      end
    end
  end

  // Data FSM state register; mem_busy is registered alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= CLEAR;
      mem_busy <= 1'b1;
    end else begin
      state    <= state_next;
      mem_busy <= (state_next == CLEAR);
    end
  end

  assign clr_last_c = (clr_ctr == '1);

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_last_c) state_next = READY;
      READY:   state_next = READY;
      default: state_next = CLEAR;
    endcase
  end

  // Single data write port shared by the clear sweep and stores.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_waddr_c = data_wr_addr;
    mem_wdata_c = datamem_wr_data;
    rd_req_c    = 1'b0;
    case (state)
      CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = clr_ctr;
        mem_wdata_c = '0;
      end
      READY: begin
        mem_we_c = store_to_mem;
        rd_req_c = data_rd_en;
      end
      default: ;
    endcase
  end

  // Counter saturates on the last address so the sweep never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               clr_ctr <= '0;
    else if (state == CLEAR && !clr_last_c)  clr_ctr <= clr_ctr + DADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) dmem[mem_waddr_c] <= mem_wdata_c;
  end

  assign rd_fwd_c = mem_we_c && (mem_waddr_c == data_rd_addr);

  // Two-stage read pipeline, one result per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_v1            <= 1'b0;
      rd_d1            <= '0;
      datamem_rd_valid <= 1'b0;
      datamem_rd_data  <= '0;
    end else begin
      rd_v1 <= rd_req_c;
      if (rd_req_c) rd_d1 <= rd_fwd_c ? datamem_wr_data : dmem[data_rd_addr];
      datamem_rd_valid <= rd_v1;
      if (rd_v1) datamem_rd_data <= rd_d1;
    end
  end

endmodule

// File: tb/tb_param_instr_data_mem.sv
// Randomised and directed bench for param_instr_data_mem against a
// cycle-level behavioural model of both memories.
module tb_param_instr_data_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  prog_ctr;
  logic        fetch_en;
  logic [15:0] instr_mem_out;
  logic        instr_valid;
  logic        imem_wr_en;
  logic [9:0]  imem_wr_addr;
  logic [15:0] imem_wr_data;
  logic        data_rd_en;
  logic [7:0]  data_rd_addr;
  logic [7:0]  datamem_rd_data;
  logic        datamem_rd_valid;
  logic        store_to_mem;
  logic [7:0]  data_wr_addr;
  logic [7:0]  datamem_wr_data;
  logic        mem_busy;

  param_instr_data_mem dut (
    .clk(clk), .reset(reset),
    .prog_ctr(prog_ctr), .fetch_en(fetch_en),
    .instr_mem_out(instr_mem_out), .instr_valid(instr_valid),
    .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
    .data_rd_en(data_rd_en), .data_rd_addr(data_rd_addr),
    .datamem_rd_data(datamem_rd_data), .datamem_rd_valid(datamem_rd_valid),
    .store_to_mem(store_to_mem), .data_wr_addr(data_wr_addr),
    .datamem_wr_data(datamem_wr_data), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         v;
    logic [7:0] d;
  } rd_t;

  logic [15:0] imem_m [1024];
  logic [7:0]  dmem_m [256];
  rd_t         rq [$];
  int          busy_cnt;
  logic [7:0]  exp_rd;
  logic        exp_iv;
  logic [15:0] exp_iout;
  int          checks;
  int          failures;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    fetch_en = 1'b0; prog_ctr = '0;
    imem_wr_en = 1'b0; imem_wr_addr = '0; imem_wr_data = '0;
    data_rd_en = 1'b0; data_rd_addr = '0;
    store_to_mem = 1'b0; data_wr_addr = '0; datamem_wr_data = '0;
  endtask

  // One clock: advance the model from the current inputs, clock the DUT, compare.
  task automatic step();
    bit  busy_pre;
    rd_t e;
    rd_t o;
    busy_pre = (busy_cnt < 256);
    e.v = data_rd_en && !busy_pre;
    e.d = (store_to_mem && data_wr_addr == data_rd_addr) ? datamem_wr_data : dmem_m[data_rd_addr];
    if (store_to_mem && !busy_pre) dmem_m[data_wr_addr] = datamem_wr_data;
    rq.push_back(e);
    if (imem_wr_en) imem_m[imem_wr_addr] = imem_wr_data;
    exp_iv = fetch_en;
    if (fetch_en) exp_iout = imem_m[prog_ctr];
    if (busy_cnt < 256) busy_cnt++;
    @(posedge clk); #1;
    o = rq.pop_front();
    if (o.v) exp_rd = o.d;
    chk("mem_busy", 32'(mem_busy), 32'(busy_cnt < 256));
    chk("rd_valid", 32'(datamem_rd_valid), 32'(o.v));
    chk("rd_data", 32'(datamem_rd_data), 32'(exp_rd));
    chk("instr_valid", 32'(instr_valid), 32'(exp_iv));
    chk("instr_out", 32'(instr_mem_out), 32'(exp_iout));
  endtask

  // Assert reset asynchronously mid-cycle, check, hold over one edge, release.
  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("rst_busy", 32'(mem_busy), 32'd1);
    chk("rst_rd_valid", 32'(datamem_rd_valid), 32'd0);
    chk("rst_rd_data", 32'(datamem_rd_data), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr_out", 32'(instr_mem_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 256; i++) dmem_m[i] = '0;
    rq.delete();
    rq.push_back('{v: 1'b0, d: 8'h00});
    exp_rd = '0; exp_iv = 1'b0; exp_iout = '0;
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (!mem_busy) break;
      n++;
      step();
    end
    chk(tag, 32'(n), 32'd256);
  endtask

  initial begin
    int n;
    checks = 0; failures = 0;
    idle_inputs();
    reset = 1'b0;
    #2;
    do_reset();

    // Load every instruction word while the data side clears, fetching the same address.
    n = 0;
    for (int i = 0; i < 1024; i++) begin
      if (mem_busy) n++;
      imem_wr_en = 1'b1; imem_wr_addr = 10'(i); imem_wr_data = 16'($urandom);
      fetch_en = 1'($urandom); prog_ctr = 10'(i);
      step();
    end
    chk("busy_len_first", 32'(n), 32'd256);
    idle_inputs();

    // Cleared memory reads back zero.
    data_rd_en = 1'b1; data_rd_addr = 8'h7F; step();
    idle_inputs(); step();
    chk("clr_read_7f", 32'(datamem_rd_data), 32'h00);

    // Store then read back.
    store_to_mem = 1'b1; data_wr_addr = 8'h10; datamem_wr_data = 8'hA5; step();
    idle_inputs(); data_rd_en = 1'b1; data_rd_addr = 8'h10; step();
    idle_inputs(); step();
    chk("rd_a5_valid", 32'(datamem_rd_valid), 32'd1);
    chk("rd_a5_data", 32'(datamem_rd_data), 32'hA5);
    step();
    chk("rd_valid_one_cycle", 32'(datamem_rd_valid), 32'd0);

    // Same-cycle forwarding, then different-address read sees the pre-store value.
    store_to_mem = 1'b1; data_wr_addr = 8'h20; datamem_wr_data = 8'h3C;
    data_rd_en = 1'b1; data_rd_addr = 8'h20; step();
    datamem_wr_data = 8'h55; data_rd_addr = 8'h21; step();
    chk("fwd_3c", 32'(datamem_rd_data), 32'h3C);
    idle_inputs(); step();
    chk("nofwd_21", 32'(datamem_rd_data), 32'h00);

    // Instruction load/fetch, and same-cycle load+fetch.
    imem_wr_en = 1'b1; imem_wr_addr = 10'h005; imem_wr_data = 16'hBEEF; step();
    idle_inputs(); fetch_en = 1'b1; prog_ctr = 10'h005; step();
    chk("fetch_beef", 32'(instr_mem_out), 32'hBEEF);
    chk("fetch_beef_v", 32'(instr_valid), 32'd1);
    imem_wr_en = 1'b1; imem_wr_addr = 10'h006; imem_wr_data = 16'hCAFE; prog_ctr = 10'h006; step();
    chk("fetch_wf_cafe", 32'(instr_mem_out), 32'hCAFE);
    idle_inputs(); step();
    chk("instr_hold", 32'(instr_mem_out), 32'hCAFE);

    // Random traffic on a narrow address window to force collisions.
    for (int i = 0; i < 600; i++) begin
      fetch_en = 1'($urandom); prog_ctr = 10'($urandom);
      imem_wr_en = ($urandom_range(0, 3) == 0); imem_wr_addr = ($urandom_range(0, 1) != 0) ? prog_ctr : 10'($urandom);
      imem_wr_data = 16'($urandom);
      data_rd_en = 1'($urandom); data_rd_addr = 8'($urandom_range(0, 15));
      store_to_mem = 1'($urandom); data_wr_addr = 8'($urandom_range(0, 15));
      datamem_wr_data = 8'($urandom);
      if (imem_wr_addr == 10'h005) imem_wr_en = 1'b0;
      step();
    end

    // Reset with a read in flight, then drop requests made during the clear.
    idle_inputs(); data_rd_en = 1'b1; data_rd_addr = 8'h03; step();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      store_to_mem = 1'b1; data_wr_addr = 8'h01; datamem_wr_data = 8'h77;
      data_rd_en = 1'b1; data_rd_addr = 8'h01;
      step();
    end
    do_reset();
    count_busy("busy_len_after_abort");
    data_rd_en = 1'b1; data_rd_addr = 8'h01; fetch_en = 1'b1; prog_ctr = 10'h005; step();
    chk("imem_keeps_beef", 32'(instr_mem_out), 32'hBEEF);
    idle_inputs(); step();
    chk("dropped_store_01", 32'(datamem_rd_data), 32'h00);
    chk("dropped_store_v", 32'(datamem_rd_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_instr_data_mem.md
PARAM_INSTR_DATA_MEM -- requirements
Module: param_instr_data_mem

Interface
REQ-001 Parameter IADDR_W, 10, instruction address width; instruction depth SHALL be 2^IADDR_W words.
REQ-002 Parameter IDATA_W, 16, instruction word width.
REQ-003 Parameter DADDR_W, 8, data address width; data depth SHALL be 2^DADDR_W words.
REQ-004 Parameter DDATA_W, 8, data word width.
REQ-005 Port clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 Port reset  in  1  asynchronous, active-high reset.
REQ-007 Port prog_ctr  in  IADDR_W  instruction fetch address.
REQ-008 Port fetch_en  in  1  fetch request.
REQ-009 Port instr_mem_out  out  IDATA_W  fetched instruction.
REQ-010 Port instr_valid  out  1  instr_mem_out holds a fetch result this cycle.
REQ-011 Port imem_wr_en / imem_wr_addr / imem_wr_data  in  1 / IADDR_W / IDATA_W  instruction load port.
REQ-012 Port data_rd_en / data_rd_addr  in  1 / DADDR_W  data read request and address.
REQ-013 Port datamem_rd_data  out  DDATA_W  read result; datamem_rd_valid  out  1  result qualifier.
REQ-014 Port store_to_mem / data_wr_addr / datamem_wr_data  in  1 / DADDR_W / DDATA_W  data store request.
REQ-015 Port mem_busy  out  1  high while the data-clear sequence runs; all data requests are ignored.

Function
REQ-016 Instruction read: when fetch_en=1 at edge N, instr_mem_out SHALL equal instr_mem[prog_ctr] at edge N+1 and instr_valid SHALL be 1 for that cycle; otherwise instr_valid=0 and instr_mem_out holds its value.
REQ-017 Instruction load: imem_wr_en=1 writes imem_wr_data at imem_wr_addr on the edge; a same-cycle fetch of that address SHALL return the new data (write-first).
REQ-018 Instruction fetch and load SHALL operate independently of mem_busy.
REQ-019 Data read: when data_rd_en=1 and mem_busy=0 at edge N, datamem_rd_data SHALL present data_mem[data_rd_addr] after edge N+1, with datamem_rd_valid=1 for exactly one cycle.
REQ-020 Data store: store_to_mem=1 with mem_busy=0 writes datamem_wr_data at data_wr_addr on the edge.
REQ-021 Same-cycle read and store to the same address SHALL forward: the read returns datamem_wr_data (replaces the old no-same-address restriction).
REQ-022 Same-cycle read and store to different addresses SHALL both complete; the read returns the pre-store value.
REQ-023 Back-to-back reads every cycle SHALL be supported at full throughput, one result per cycle.
REQ-024 Data FSM states: CLEAR, READY. CLEAR: write 0 at clr_ctr, increment clr_ctr each cycle; at clr_ctr = 2^DADDR_W-1 the write completes and the FSM moves to READY on that edge.
REQ-025 mem_busy SHALL be 1 exactly while in CLEAR (2^DADDR_W cycles after reset release); READY has no exit except reset.
REQ-026 Requests presented while mem_busy=1 SHALL be dropped: no write, datamem_rd_valid stays 0.
REQ-027 clr_ctr SHALL be DADDR_W bits wide; no wrap beyond the final address is permitted.

Reset
REQ-028 While reset=1: FSM=CLEAR, clr_ctr=0, mem_busy=1, instr_valid=0, datamem_rd_valid=0, instr_mem_out=0, datamem_rd_data=0, asynchronously.
REQ-029 Reset asserted mid-CLEAR or mid-read SHALL abort the operation; the clear sequence restarts from address 0 after release.
REQ-030 Instruction memory contents SHALL NOT be altered by reset.

Verification
REQ-031 Release reset, idle -> mem_busy=1 for exactly 256 cycles (defaults), then 0; read any address -> 0x00.
REQ-032 After clear, store 0xA5 at 0x10, next cycle read 0x10 -> datamem_rd_data=0xA5, datamem_rd_valid=1 one cycle later.
REQ-033 Same cycle: store 0x3C at 0x20 and read 0x20 (old 0x00) -> read returns 0x3C; read of 0x21 with store to 0x20 -> 0x00.
REQ-034 Load imem[0x005]=0xBEEF, fetch prog_ctr=0x005 with fetch_en=1 -> instr_mem_out=0xBEEF, instr_valid=1 next cycle; same-cycle load+fetch returns new word.
REQ-035 Store 0x77 at 0x01 while mem_busy=1 -> dropped; after clear, read 0x01 -> 0x00, no datamem_rd_valid during busy.
REQ-036 Assert reset at clear cycle 100, release -> mem_busy high for a full 256 cycles again; imem[0x005] still 0xBEEF.
